multicycle_control_unit: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including the 2-bit `alu_op` consumed by the ALU control unit. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/multicycle_control_unit.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back and drives all datapath controls.
module multicycle_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    state_t r_state;
    state_t w_next;

    logic w_op_rtype;
    logic w_op_lw;
    logic w_op_sw;
    logic w_op_beq;
    logic w_op_addi;
    logic w_op_j;
    logic w_op_mem;
    logic w_op_legal;

    // opcode class decode, consumed only in DECODE and MEMADR
    assign w_op_rtype = (opcode == OP_RTYPE);
    assign w_op_lw    = (opcode == OP_LW);
    assign w_op_sw    = (opcode == OP_SW);
    assign w_op_beq   = (opcode == OP_BEQ);
    assign w_op_addi  = (opcode == OP_ADDI);
    assign w_op_j     = (opcode == OP_J);
    assign w_op_mem   = w_op_lw | w_op_sw;
    assign w_op_legal = w_op_mem | w_op_rtype | w_op_beq
                      | w_op_addi | w_op_j;

    // next-state selection; memory states hold until mem_ready
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_op_mem)
                    w_next = S_MEMADR;
                else if (w_op_rtype)
                    w_next = S_EXECUTE;
                else if (w_op_beq)
                    w_next = S_BRANCH;
                else if (w_op_addi)
                    w_next = S_ADDIEXEC;
                else if (w_op_j)
                    w_next = S_JUMP;
                else
                    w_next = S_FETCH;
            end
            S_MEMADR:   w_next = w_op_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWR:    w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEXEC: w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // state register; reset wins even mid-stall
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    // control decode from the state register; the IR/PC write in FETCH
    // and the illegal-opcode flag in DECODE also look at live inputs
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_BOFF;
                    illegal_op = ~w_op_legal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FN;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_OUT;
                end
                S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    // debug view of the state, blanked while in reset
    assign state = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit.
// Builds each instruction's expected cycle trace and checks it cycle by cycle.
module tb_multicycle_control_unit;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .ir_write(ir_write), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] w_obs;
    assign w_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                    mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a,
                    alu_src_b, alu_op, pc_source, illegal_op};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == LW || op == SW || op == RT ||
               op == BEQ || op == ADDI || op == JMP;
    endfunction

    // expected control word for a state, given the cycle's ready/legality
    function automatic logic [16:0] exp_ctrl(input int s, input bit rd,
                                             input bit ill);
        logic pw, pwc, iod, mr, mw, m2r, irw, rdst, rw, asa, il;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mr, mw, m2r, irw, rdst, rw, asa, il} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mr = 1; asb = 2'b01; irw = rd; pw = rd; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: begin rw = 1; end
            11: begin pw = 1; psrc = 2'b10; end
            default: begin pw = 0; end
        endcase
        return {pw, pwc, iod, mr, mw, m2r, irw, rdst, rw, asa,
                asb, aop, psrc, il};
    endfunction

    // fs: fetch stall cycles, ms: data-memory stall cycles,
    // rst_at: trace index at which reset is pulsed (-1 = none)
    task automatic run_instr(input logic [5:0] op, input int fs,
                             input int ms, input int rst_at);
        int st[$];
        bit rd[$];
        bit rnd;
        for (int i = 0; i < fs; i++) begin st.push_back(0); rd.push_back(0); end
        st.push_back(0); rd.push_back(1);
        rnd = bit'($urandom_range(0, 1));
        st.push_back(1); rd.push_back(rnd);
        if (op == LW || op == SW) begin
            rnd = bit'($urandom_range(0, 1));
            st.push_back(2); rd.push_back(rnd);
            for (int i = 0; i < ms; i++) begin
                st.push_back(op == LW ? 3 : 5); rd.push_back(0);
            end
            st.push_back(op == LW ? 3 : 5); rd.push_back(1);
            if (op == LW) begin
                rnd = bit'($urandom_range(0, 1));
                st.push_back(4); rd.push_back(rnd);
            end
        end else if (op == RT) begin
            st.push_back(6); rd.push_back(1'b0);
            st.push_back(7); rd.push_back(1'b1);
        end else if (op == BEQ) begin
            st.push_back(8); rd.push_back(1'b0);
        end else if (op == ADDI) begin
            st.push_back(9); rd.push_back(1'b1);
            st.push_back(10); rd.push_back(1'b0);
        end else if (op == JMP) begin
            st.push_back(11); rd.push_back(1'b1);
        end
        for (int c = 0; c < st.size(); c++) begin
            @(negedge clk);
            rst = (c == rst_at);
            mem_ready = rd[c];
            opcode = (st[c] == 0) ? 6'($urandom) : op;
            #1;
            if (rst) begin
                chk("rst_state", 32'(state), 32'd0);
                chk("rst_ctrl", 32'(w_obs), 32'd0);
                break;
            end
            chk("state", 32'(state), 32'(st[c]));
            chk("ctrl", 32'(w_obs), 32'(exp_ctrl(st[c], rd[c], !legal(op))));
            chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] op;
        case ($urandom_range(0, 6))
            0: op = LW;
            1: op = SW;
            2: op = RT;
            3: op = BEQ;
            4: op = ADDI;
            5: op = JMP;
            default: begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end
        endcase
        return op;
    endfunction

    initial begin
        // two reset cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem_ready = bit'($urandom_range(0, 1));
            opcode = 6'($urandom);
            #1;
            chk("init_state", 32'(state), 32'd0);
            chk("init_ctrl", 32'(w_obs), 32'd0);
        end
        run_instr(RT, 0, 0, -1);
        run_instr(LW, 0, 3, -1);
        run_instr(SW, 0, 0, -1);
        run_instr(BEQ, 0, 0, -1);
        run_instr(JMP, 0, 0, -1);
        run_instr(6'b111111, 2, 0, -1);
        run_instr(SW, 0, 2, 4);
        run_instr(ADDI, 0, 0, -1);
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            int fs, ms, ra;
            op = pick_op();
            fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ms = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(op, fs, ms, ra);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
